exp_issue_arbiter: RTL and testbench

Shares one bfloat16 exp pipeline (2-cycle latency, free-running, no stall, no reset) between NUM_REQ requesters. Each cycle it grants one requester round-robin and drives its operand into the exp unit. It tracks each operation's requester id and tag through a shadow pipeline, then captures results into a response FIFO. Issue is credit-gated so results are never dropped when the consumer backpressures.

---
 rtl/exp_issue_arbiter.sv | 131 +++++++++++++
 tb/tb_exp_issue_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_issue_arbiter.sv
// Round-robin issue of bf16 operands from NUM_REQ requesters into one shared, free-running exp unit.
// A shadow pipeline carries id/tag beside each op and results land in a credit-gated show-ahead FIFO.
module exp_issue_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int TAG_W      = 4,
  parameter int EXP_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [16*NUM_REQ-1:0]    req_data,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic [15:0]              exp_in,
  input  logic [15:0]              exp_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + EXP_LAT + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [EXP_LAT-1:0] sh_v_q;
  logic [ID_W-1:0]    sh_id_q   [EXP_LAT];
  logic [TAG_W-1:0]   sh_tag_q  [EXP_LAT];
  logic [15:0]        fifo_data_q [FIFO_DEPTH];
  logic [ID_W-1:0]    fifo_id_q   [FIFO_DEPTH];
  logic [TAG_W-1:0]   fifo_tag_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, inflight;
  logic               can_issue, gnt_found, issue, push, pop;
  logic [ID_W-1:0]    gnt;
  logic [15:0]        gnt_data;
  logic [TAG_W-1:0]   gnt_tag;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits: every op in flight or buffered owns a FIFO slot; a same-cycle pop is not counted.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < EXP_LAT; i++) inflight = inflight + CNT_W'(sh_v_q[i]);
  end

  assign can_issue = !rst && ((inflight + cnt_q) < CNT_W'(FIFO_DEPTH));

  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_found && req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt       = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    gnt_tag  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt) begin
        gnt_data = req_data[16*i +: 16];
        gnt_tag  = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  assign issue  = can_issue && gnt_found;
  assign exp_in = issue ? gnt_data : 16'h0000;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt] = 1'b1;
  end

  assign last_grant_d = issue ? gnt : last_grant_q;

  assign push      = sh_v_q[EXP_LAT-1] && !rst;
  assign rsp_valid = !rst && (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
  assign wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

  assign rsp_data = fifo_data_q[rd_ptr_q];
  assign rsp_id   = fifo_id_q[rd_ptr_q];
  assign rsp_tag  = fifo_tag_q[rd_ptr_q];
  assign busy     = !rst && ((|sh_v_q) || (cnt_q != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      sh_v_q       <= '0;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      sh_v_q[0]    <= issue;
      for (int i = 1; i < EXP_LAT; i++) sh_v_q[i] <= sh_v_q[i-1];
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Payload shadows and FIFO storage need no reset: only the valid bits and count qualify them.
  always_ff @(posedge clk) begin
    sh_id_q[0]  <= gnt;
    sh_tag_q[0] <= gnt_tag;
    for (int i = 1; i < EXP_LAT; i++) begin
      sh_id_q[i]  <= sh_id_q[i-1];
      sh_tag_q[i] <= sh_tag_q[i-1];
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= exp_out;
      fifo_id_q[wr_ptr_q]   <= sh_id_q[EXP_LAT-1];
      fifo_tag_q[wr_ptr_q]  <= sh_tag_q[EXP_LAT-1];
    end
  end

endmodule

// File: tb/tb_exp_issue_arbiter.sv
// Bench for exp_issue_arbiter: vector table, hand sequences and a queue-based scoreboard,
// with a 2-cycle stand-in exp unit.
module tb_exp_issue_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int TAG_W      = 4;
  localparam int EXP_LAT    = 2;
  localparam int FIFO_DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid, req_ready;
  logic [16*NUM_REQ-1:0]    req_data;
  logic [TAG_W*NUM_REQ-1:0] req_tag;
  logic [15:0]              exp_in, exp_out, rsp_data;
  logic                     rsp_valid, rsp_ready, busy;
  logic [ID_W-1:0]          rsp_id;
  logic [TAG_W-1:0]         rsp_tag;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  exp_issue_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TAG_W(TAG_W),
                      .EXP_LAT(EXP_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_tag(req_tag), .exp_in(exp_in), .exp_out(exp_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .busy(busy));

  // Stand-in exp unit: known bf16 results for the directed operands, a scramble otherwise.
  function automatic logic [15:0] exp_ref(input logic [15:0] x);
    case (x)
      16'h3f80: return 16'h402d;
      16'h4000: return 16'h40ec;
      16'hbf80: return 16'h3ebc;
      default:  return {x[7:0], x[15:8]} ^ 16'h5a3c;
    endcase
  endfunction

  logic [15:0] eu_s1, eu_s2;
  always @(posedge clk) begin
    eu_s1 <= exp_in;
    eu_s2 <= eu_s1;
  end
  assign exp_out = exp_ref(eu_s2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  // Scoreboard: each issued op is outstanding until popped; it becomes visible EXP_LAT+1 cycles after issue.
  typedef struct {
    logic [15:0]      data;
    int               id;
    logic [TAG_W-1:0] tag;
    int               due;
  } sb_t;
  sb_t sb[$];
  int                 m_last = NUM_REQ - 1;
  int                 m_g;
  logic [NUM_REQ-1:0] m_rdy;
  logic [15:0]        m_in;
  logic               m_rv;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_exp_in", 32'(exp_in), 32'd0);
      sb.delete();
      m_last = NUM_REQ - 1;
    end else begin
      m_g   = ((|req_valid) && (sb.size() < FIFO_DEPTH)) ? rr_pick(req_valid, m_last) : -1;
      m_rdy = '0;
      m_in  = 16'h0000;
      if (m_g >= 0) begin
        m_rdy[m_g] = 1'b1;
        m_in       = req_data[16*m_g +: 16];
      end
      m_rv = (sb.size() != 0) && (sb[0].due <= cyc);
      chk("sb_req_ready", 32'(req_ready), 32'(m_rdy));
      chk("sb_exp_in", 32'(exp_in), 32'(m_in));
      chk("sb_rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("sb_busy", 32'(busy), 32'(sb.size() != 0));
      if (m_rv) begin
        chk("sb_rsp_data", 32'(rsp_data), 32'(sb[0].data));
        chk("sb_rsp_id", 32'(rsp_id), 32'(sb[0].id));
        chk("sb_rsp_tag", 32'(rsp_tag), 32'(sb[0].tag));
        if (rsp_ready) void'(sb.pop_front());
      end
      if (m_g >= 0) begin
        sb.push_back('{exp_ref(m_in), m_g, req_tag[TAG_W*m_g +: TAG_W], cyc + EXP_LAT + 1});
        m_last = m_g;
      end
    end
    cyc++;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [15:0] d0, d2;
    logic        rr;
    logic [3:0]  e_rdy;
    logic [15:0] e_in;
    logic        e_rv;
    logic [15:0] e_rd;
    logic [1:0]  e_rid;
    logic [3:0]  e_rtag;
    logic        e_busy;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] vld, input logic [15:0] d0,
                              input logic [15:0] d2, input logic rr, input logic [3:0] e_rdy,
                              input logic [15:0] e_in, input logic e_rv, input logic [15:0] e_rd,
                              input logic [1:0] e_rid, input logic [3:0] e_rtag, input logic e_busy);
    vec_t v;
    v.rst = r; v.vld = vld; v.d0 = d0; v.d2 = d2; v.rr = rr; v.e_rdy = e_rdy; v.e_in = e_in;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_rid = e_rid; v.e_rtag = e_rtag; v.e_busy = e_busy;
    return v;
  endfunction

  logic [NUM_REQ-1:0] acc_q = '0;
  logic [NUM_REQ-1:0] s_rdy;
  logic               s_rv, s_busy;
  int                 n_iss;
  int                 rr_pct;

  // One clock cycle of requester behaviour: unaccepted requests are held, accepted ones may be replaced.
  task automatic step(input bit r, input bit rr, input logic [NUM_REQ-1:0] want, input int pct);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_q[i] || !req_valid[i]) begin
        if (want[i] && ($urandom_range(0, 99) < pct)) begin
          req_valid[i]               = 1'b1;
          req_data[16*i +: 16]       = 16'($urandom);
          req_tag[TAG_W*i +: TAG_W]  = TAG_W'($urandom);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    rst       = r;
    rsp_ready = rr;
    @(negedge clk);
    acc_q  = req_valid & req_ready;
    s_rdy  = req_ready;
    s_rv   = rsp_valid;
    s_busy = busy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_tag = '0; rsp_ready = 1'b1;

    // Single op latency, then alternating req0/req2 at full rate.
    vecs.push_back(mk(1, 4'b0000, 16'h0, 16'h0, 1, 4'b0000, 16'h0, 0, 16'h0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 16'h0, 16'h0, 1, 4'b0000, 16'h0, 0, 16'h0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 16'h3f80, 16'h0, 1, 4'b0001, 16'h3f80, 0, 16'h0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 16'h0, 16'h0, 1, 4'b0000, 16'h0, 0, 16'h0, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 16'h0, 16'h0, 1, 4'b0000, 16'h0, 0, 16'h0, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 16'h0, 16'h0, 1, 4'b0000, 16'h0, 1, 16'h402d, 0, 5, 1));
    vecs.push_back(mk(0, 4'b0000, 16'h0, 16'h0, 1, 4'b0000, 16'h0, 0, 16'h0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 16'h0, 16'h0, 1, 4'b0000, 16'h0, 0, 16'h0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0101, 16'h4000, 16'hbf80, 1, 4'b0001, 16'h4000, 0, 16'h0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0101, 16'h4000, 16'hbf80, 1, 4'b0100, 16'hbf80, 0, 16'h0, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0101, 16'h4000, 16'hbf80, 1, 4'b0001, 16'h4000, 0, 16'h0, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0101, 16'h4000, 16'hbf80, 1, 4'b0100, 16'hbf80, 1, 16'h40ec, 0, 5, 1));
    vecs.push_back(mk(0, 4'b0101, 16'h4000, 16'hbf80, 1, 4'b0001, 16'h4000, 1, 16'h3ebc, 2, 7, 1));
    vecs.push_back(mk(0, 4'b0101, 16'h4000, 16'hbf80, 1, 4'b0100, 16'hbf80, 1, 16'h40ec, 0, 5, 1));
    vecs.push_back(mk(0, 4'b0000, 16'h4000, 16'hbf80, 1, 4'b0000, 16'h0, 1, 16'h3ebc, 2, 7, 1));
    vecs.push_back(mk(0, 4'b0000, 16'h4000, 16'hbf80, 1, 4'b0000, 16'h0, 1, 16'h40ec, 0, 5, 1));
    vecs.push_back(mk(0, 4'b0000, 16'h4000, 16'hbf80, 1, 4'b0000, 16'h0, 1, 16'h3ebc, 2, 7, 1));
    vecs.push_back(mk(0, 4'b0000, 16'h4000, 16'hbf80, 1, 4'b0000, 16'h0, 0, 16'h0, 0, 0, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      req_valid = vecs[i].vld;
      req_data  = {16'h0, vecs[i].d2, 16'h0, vecs[i].d0};
      req_tag   = {4'd8, 4'd7, 4'd6, 4'd5};
      rsp_ready = vecs[i].rr;
      @(negedge clk);
      chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_exp_in", i), 32'(exp_in), 32'(vecs[i].e_in));
      chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_rv) begin
        chk($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].e_rd));
        chk($sformatf("vec%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].e_rid));
        chk($sformatf("vec%0d_rsp_tag", i), 32'(rsp_tag), 32'(vecs[i].e_rtag));
      end
      @(posedge clk);
      #1;
    end
    acc_q = '0;

    // All requesters valid, consumer always ready: one grant per cycle in 0,1,2,3 order.
    step(1, 1, '0, 0);
    n_iss = 0;
    for (int c = 0; c < 40; c++) begin
      step(0, 1, '1, 100);
      n_iss += $countones(acc_q);
      chk("rr_grant_order", 32'(s_rdy), 32'(1 << (c % NUM_REQ)));
    end
    chk("rr_full_rate", 32'(n_iss), 32'd40);

    // Consumer stalled: exactly FIFO_DEPTH issues, then toggled drain.
    step(1, 1, '0, 0);
    n_iss = 0;
    for (int c = 0; c < 10; c++) begin
      step(0, 0, '1, 100);
      n_iss += $countones(acc_q);
    end
    chk("full_issue_count", 32'(n_iss), 32'(FIFO_DEPTH));
    chk("full_ready_idle", 32'(s_rdy), 32'd0);
    chk("full_busy", 32'(s_busy), 32'd1);
    chk("full_rsp_valid", 32'(s_rv), 32'd1);
    step(0, 1, '1, 100);
    step(0, 0, '1, 100);
    step(0, 1, '1, 100);
    for (int c = 0; c < 20; c++) step(0, 1, '1, 100);

    // Reset with two ops in flight and two buffered.
    step(1, 1, '0, 0);
    for (int c = 0; c < 4; c++) step(0, 0, '1, 100);
    chk("pre_rst_rsp_valid", 32'(s_rv), 32'd1);
    step(1, 0, '1, 100);
    chk("rst_pulse_ready", 32'(s_rdy), 32'd0);
    chk("rst_pulse_busy", 32'(s_busy), 32'd0);
    step(0, 1, '1, 100);
    chk("post_rst_rsp_valid", 32'(s_rv), 32'd0);
    chk("post_rst_busy", 32'(s_busy), 32'd0);
    chk("post_rst_grant", 32'(s_rdy), 32'd1);
    for (int c = 0; c < 10; c++) step(0, 1, '1, 100);

    // Randomised traffic with varying backpressure and occasional resets.
    for (int p = 0; p < 3; p++) begin
      case (p)
        0: rr_pct = 90;
        1: rr_pct = 50;
        default: rr_pct = 10;
      endcase
      for (int c = 0; c < 1500; c++)
        step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < rr_pct,
             NUM_REQ'($urandom), 70);
    end
    for (int c = 0; c < 12; c++) step(0, 1, '0, 0);
    chk("drain_busy", 32'(s_busy), 32'd0);
    chk("drain_rsp_valid", 32'(s_rv), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
